// File: rtl/zap_mem_arbiter_if.sv
// zap_mem_arbiter_if: I-side, D-side and memory bus signals of the arbiter.
// The slave modport is the arbiter's view; the master modport is the core and memory.
interface zap_mem_arbiter_if;
    logic        i_i_req;
    logic [31:0] i_i_addr;
    logic        o_i_ack;
    logic [31:0] o_i_rdata;
    logic        o_i_abort;
    logic        i_d_req;
    logic        i_d_we;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wdata;
    logic [3:0]  i_d_be;
    logic        o_d_ack;
    logic [31:0] o_d_rdata;
    logic        o_d_abort;
    logic        o_m_req;
    logic        o_m_we;
    logic [31:0] o_m_addr;
    logic [31:0] o_m_wdata;
    logic [3:0]  o_m_be;
    logic        i_m_ack;
    logic [31:0] i_m_rdata;
    logic        i_m_err;

    modport slave (
        input  i_i_req, i_i_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
        input  i_m_ack, i_m_rdata, i_m_err,
        output o_i_ack, o_i_rdata, o_i_abort, o_d_ack, o_d_rdata, o_d_abort,
        output o_m_req, o_m_we, o_m_addr, o_m_wdata, o_m_be
    );

    modport master (
        output i_i_req, i_i_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
        output i_m_ack, i_m_rdata, i_m_err,
        input  o_i_ack, o_i_rdata, o_i_abort, o_d_ack, o_d_rdata, o_d_abort,
        input  o_m_req, o_m_we, o_m_addr, o_m_wdata, o_m_be
    );
endinterface

// File: rtl/zap_mem_arbiter.sv
// zap_mem_arbiter: shares one memory bus between I-fetch and D load/store, D priority with starvation bound.
module zap_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    zap_mem_arbiter_if.slave          bus,
    output logic                      o_busy
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    localparam logic [3:0] SL = STARVE_LIMIT[3:0];
    localparam logic [7:0] TL = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [7:0]  timer_q, timer_d;
    logic        m_req_q, m_req_d, m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
    logic [3:0]  m_be_q, m_be_d;
    logic        i_ack_q, i_ack_d, i_abort_q, i_abort_d;
    logic        d_ack_q, d_ack_d, d_abort_q, d_abort_d;
    logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic        busy_q, busy_d;
    logic        grant_d, grant_i, done, ok;

    assign grant_d = bus.i_d_req && (!bus.i_i_req || starve_q < SL);
    assign grant_i = bus.i_i_req && !grant_d;
    // Error beats a simultaneous ack; the timer expiring counts as a fault too.
    assign done    = bus.i_m_err || bus.i_m_ack || timer_q == TL;
    assign ok      = !bus.i_m_err && bus.i_m_ack;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            timer_q   <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_be_q    <= '0;
            i_ack_q   <= 1'b0;
            i_abort_q <= 1'b0;
            d_ack_q   <= 1'b0;
            d_abort_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            timer_q   <= timer_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_be_q    <= m_be_d;
            i_ack_q   <= i_ack_d;
            i_abort_q <= i_abort_d;
            d_ack_q   <= d_ack_d;
            d_abort_q <= d_abort_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:           state_d = grant_d ? BUSY_D : grant_i ? BUSY_I : IDLE;
            BUSY_I, BUSY_D: state_d = done ? RESP : state_q;
            default:        state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d  = starve_q;
        timer_d   = timer_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_be_d    = m_be_q;
        i_ack_d   = 1'b0;
        i_abort_d = 1'b0;
        d_ack_d   = 1'b0;
        d_abort_d = 1'b0;
        i_rdata_d = '0;
        d_rdata_d = '0;
        busy_d    = state_d != IDLE;
        case (state_q)
            IDLE: begin
                if (grant_d || grant_i) begin
                    m_req_d   = 1'b1;
                    timer_d   = '0;
                    m_we_d    = grant_d && bus.i_d_we;
                    m_addr_d  = grant_d ? bus.i_d_addr : bus.i_i_addr;
                    m_wdata_d = grant_d ? bus.i_d_wdata : '0;
                    m_be_d    = grant_d ? bus.i_d_be : 4'hF;
                    starve_d  = !(grant_d && bus.i_i_req) ? '0 :
                                starve_q == SL ? starve_q : starve_q + 4'd1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    m_req_d   = 1'b0;
                    i_ack_d   = state_q == BUSY_I && ok;
                    i_abort_d = state_q == BUSY_I && !ok;
                    d_ack_d   = state_q == BUSY_D && ok;
                    d_abort_d = state_q == BUSY_D && !ok;
                    i_rdata_d = i_ack_d ? bus.i_m_rdata : '0;
                    d_rdata_d = d_ack_d && !m_we_q ? bus.i_m_rdata : '0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.o_m_req   = m_req_q;
    assign bus.o_m_we    = m_we_q;
    assign bus.o_m_addr  = m_addr_q;
    assign bus.o_m_wdata = m_wdata_q;
    assign bus.o_m_be    = m_be_q;
    assign bus.o_i_ack   = i_ack_q;
    assign bus.o_i_abort = i_abort_q;
    assign bus.o_i_rdata = i_rdata_q;
    assign bus.o_d_ack   = d_ack_q;
    assign bus.o_d_abort = d_abort_q;
    assign bus.o_d_rdata = d_rdata_q;
    assign o_busy        = busy_q;
endmodule

// File: tb/tb_zap_mem_arbiter.sv
// tb_zap_mem_arbiter: scoreboard bench; stimulus pushes expected bus grants and responses,
// a monitor pops and compares them whenever the arbiter drives the bus or a pulse.
module tb_zap_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    zap_mem_arbiter_if bif();

    zap_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .bus(bif), .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_t;

    typedef struct packed {
        logic [3:0]  pulse;
        logic [31:0] i_rdata;
        logic [31:0] d_rdata;
    } rsp_t;

    bus_t exp_bus[$];
    rsp_t exp_rsp[$];
    int n_checks = 0;
    int n_pass = 0;
    int mem_lat = 1;
    int mem_mode = 0;
    logic mem_fixed_en = 1'b0;
    logic [31:0] mem_fixed = '0;
    logic stray = 1'b0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [159:0] outs();
        return {bif.o_i_ack, bif.o_i_rdata, bif.o_i_abort, bif.o_d_ack, bif.o_d_rdata,
                bif.o_d_abort, bif.o_m_req, bif.o_m_we, bif.o_m_addr, bif.o_m_wdata,
                bif.o_m_be, busy};
    endfunction

    task automatic exp_i(input logic [31:0] a, input logic ab, input logic [31:0] rd);
        bus_t b;
        rsp_t r;
        b.we = 1'b0; b.addr = a; b.wdata = '0; b.be = 4'hF;
        r.pulse = ab ? 4'b0100 : 4'b1000; r.i_rdata = ab ? '0 : rd; r.d_rdata = '0;
        exp_bus.push_back(b);
        exp_rsp.push_back(r);
    endtask

    task automatic exp_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic ab, input logic [31:0] rd);
        bus_t b;
        rsp_t r;
        b.we = we; b.addr = a; b.wdata = wd; b.be = be;
        r.pulse = ab ? 4'b0001 : 4'b0010; r.i_rdata = '0; r.d_rdata = ab ? '0 : rd;
        exp_bus.push_back(b);
        exp_rsp.push_back(r);
    endtask

    task automatic req_i(input int n, input logic [31:0] base);
        int w;
        for (int k = 0; k < n; k++) begin
            bif.i_i_req = 1'b1;
            bif.i_i_addr = base + 32'(4 * k);
            w = 0;
            do begin
                @(posedge clk); #1; w++;
            end while (!(bif.o_i_ack || bif.o_i_abort) && w < 200);
            chk("i_pulse_seen", {159'd0, w < 200}, 160'd1);
            @(posedge clk); #1;
        end
        bif.i_i_req = 1'b0;
    endtask

    task automatic req_d(input int n, input logic [31:0] base, input logic we,
                         input logic [31:0] wd, input logic [3:0] be);
        int w;
        for (int k = 0; k < n; k++) begin
            bif.i_d_req = 1'b1;
            bif.i_d_we = we;
            bif.i_d_addr = base + 32'(4 * k);
            bif.i_d_wdata = wd;
            bif.i_d_be = be;
            w = 0;
            do begin
                @(posedge clk); #1; w++;
            end while (!(bif.o_d_ack || bif.o_d_abort) && w < 200);
            chk("d_pulse_seen", {159'd0, w < 200}, 160'd1);
            @(posedge clk); #1;
        end
        bif.i_d_req = 1'b0;
    endtask

    // Memory model: answers mem_lat cycles after o_m_req rises; read data is addr ^ 0x5A5A0000.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            bif.i_m_ack = 1'b0;
            bif.i_m_err = 1'b0;
            bif.i_m_rdata = 32'hBAD0_BAD0;
            if (stray) begin
                bif.i_m_ack = 1'b1;
                stray = 1'b0;
            end else if (bif.o_m_req) begin
                cnt++;
                if (cnt == mem_lat && mem_mode != 3) begin
                    bif.i_m_ack = mem_mode == 0 || mem_mode == 2;
                    bif.i_m_err = mem_mode == 1 || mem_mode == 2;
                    bif.i_m_rdata = mem_fixed_en ? mem_fixed : bif.o_m_addr ^ 32'h5A5A_0000;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        logic prev_req;
        logic [3:0] pulse;
        bus_t b;
        rsp_t r;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            pulse = {bif.o_i_ack, bif.o_i_abort, bif.o_d_ack, bif.o_d_abort};
            if (|pulse) begin
                if (exp_rsp.size() == 0) chk("unexpected_rsp", {124'd0, pulse, bif.o_i_rdata}, 160'd0);
                else begin
                    r = exp_rsp.pop_front();
                    chk("rsp", {92'd0, pulse, bif.o_i_rdata, bif.o_d_rdata}, {92'd0, r});
                end
            end
            if (bif.o_m_req && !prev_req) begin
                if (exp_bus.size() == 0) chk("unexpected_grant", {128'd0, bif.o_m_addr}, 160'd0);
                else begin
                    b = exp_bus.pop_front();
                    chk("bus", {91'd0, bif.o_m_we, bif.o_m_addr, bif.o_m_wdata, bif.o_m_be}, {91'd0, b});
                end
            end
            prev_req = bif.o_m_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, w;
        bif.i_i_req = 0; bif.i_i_addr = 0;
        bif.i_d_req = 0; bif.i_d_we = 0; bif.i_d_addr = 0; bif.i_d_wdata = 0; bif.i_d_be = 0;
        bif.i_m_ack = 0; bif.i_m_err = 0; bif.i_m_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs(), 160'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        mem_lat = 2; mem_mode = 0; mem_fixed_en = 1'b1; mem_fixed = 32'hE3A0_0001;
        exp_i(32'h100, 1'b0, 32'hE3A0_0001);
        req_i(1, 32'h100);
        chk("busy_after_i", {159'd0, busy}, 160'd0);
        mem_fixed_en = 1'b0;

        mem_lat = 1;
        for (int k = 0; k < 4; k++) exp_d(0, 32'h1000 + 32'(4 * k), 0, 4'hF, 0, (32'h1000 + 32'(4 * k)) ^ 32'h5A5A_0000);
        exp_i(32'h300, 0, 32'h300 ^ 32'h5A5A_0000);
        for (int k = 4; k < 8; k++) exp_d(0, 32'h1000 + 32'(4 * k), 0, 4'hF, 0, (32'h1000 + 32'(4 * k)) ^ 32'h5A5A_0000);
        exp_i(32'h304, 0, 32'h304 ^ 32'h5A5A_0000);
        fork
            req_i(2, 32'h300);
            req_d(8, 32'h1000, 1'b0, 32'h0, 4'hF);
        join

        exp_d(1, 32'h2000, 32'hDEAD_BEEF, 4'b0011, 0, 32'h0);
        req_d(1, 32'h2000, 1'b1, 32'hDEAD_BEEF, 4'b0011);

        mem_mode = 3;
        exp_d(0, 32'h3000, 0, 4'hF, 1, 32'h0);
        fork
            req_d(1, 32'h3000, 1'b0, 32'h0, 4'hF);
            begin
                c = 0; w = 0;
                while (!bif.o_m_req && w < 50) begin @(posedge clk); #1; w++; end
                while (bif.o_m_req && c < 50) begin @(posedge clk); #1; c++; end
                chk("timeout_len", 160'(c), 160'd8);
            end
        join

        mem_mode = 2;
        exp_i(32'h400, 1, 32'h0);
        req_i(1, 32'h400);

        mem_mode = 3;
        begin
            bus_t b;
            b.we = 0; b.addr = 32'h5000; b.wdata = 0; b.be = 4'hF;
            exp_bus.push_back(b);
        end
        bif.i_d_req = 1; bif.i_d_we = 0; bif.i_d_addr = 32'h5000; bif.i_d_wdata = 0; bif.i_d_be = 4'hF;
        w = 0;
        while (!bif.o_m_req && w < 50) begin @(posedge clk); #1; w++; end
        chk("rst_test_busy", {159'd0, busy}, 160'd1);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        bif.i_d_req = 0;
        @(posedge clk); #1;
        chk("reset_mid", outs(), 160'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        chk("after_stray", outs(), 160'd0);

        chk("queues_empty", 160'(exp_bus.size() + exp_rsp.size()), 160'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
